// File: rtl/conv_pe_seq_if.sv
// Result stream between conv_pe_seq and the downstream consumer.
// Carries the one-deep result register contents under a valid/ready handshake.
interface conv_pe_seq_if #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 5
);
  logic                 out_valid;
  logic                 out_ready;
  logic [3*WIDTH-1:0]   out_data;
  logic [ADDR_W-1:0]    out_row;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    output out_ready
  );
endinterface

// File: rtl/conv_pe_seq.sv
// Row sequencer for the 3x3 convolution PE.
// Walks the row buffer top to bottom with stride 1; for every window it reads
// three consecutive rows, drives pe_init aligned with the returned data, waits
// the PE latency, captures the three PE lanes and offers them downstream.
// Optional feature: define CONV_PE_SEQ_RELU_EN to clamp negative lanes to zero
// at capture (two's-complement interpretation); timing is unchanged.
module conv_pe_seq #(
  parameter int WIDTH  = 9,
  parameter int ROWS   = 32,
  parameter int ADDR_W = 5,
  parameter int PE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              row_rd_en,
  output logic [ADDR_W-1:0] row_rd_addr,
  output logic              pe_init,
  input  logic [WIDTH-1:0]  pe_data_out0,
  input  logic [WIDTH-1:0]  pe_data_out1,
  input  logic [WIDTH-1:0]  pe_data_out2,
  conv_pe_seq_if.master     res
);

  localparam int                WC_W     = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);
  localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(PE_LAT);
  localparam logic [ADDR_W-1:0] LAST_TOP = ADDR_W'(ROWS - 3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   top_row;
  logic [1:0]          ld_cnt;
  logic [WC_W-1:0]     wait_cnt;

  logic                res_valid;
  logic [3*WIDTH-1:0]  res_data;
  logic [ADDR_W-1:0]   res_row;
  logic                drain;

  // Lane conditioning applied at capture.
  function automatic logic [WIDTH-1:0] relu_lane(input logic signed [WIDTH-1:0] lane);
`ifdef CONV_PE_SEQ_RELU_EN
    relu_lane = (lane < 0) ? '0 : lane;
`else
    relu_lane = lane;
`endif
  endfunction

  assign drain         = res_valid & res.out_ready;
  assign res.out_valid = res_valid;
  assign res.out_data  = res_data;
  assign res.out_row   = res_row;

  // Sequencer FSM with registered outputs, PE init alignment and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      top_row     <= '0;
      ld_cnt      <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      row_rd_en   <= 1'b0;
      row_rd_addr <= '0;
      pe_init     <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_row     <= '0;
    end else begin
      // Read data returns one cycle after the strobe, so pe_init trails it by one.
      pe_init <= row_rd_en;

      // Downstream drain; a capture below overrides it in the same cycle.
      if (drain) begin
        res_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LOAD;
            top_row     <= '0;
            ld_cnt      <= '0;
            busy        <= 1'b1;
            row_rd_en   <= 1'b1;
            row_rd_addr <= '0;
          end
        end

        ST_LOAD: begin
          if (ld_cnt == 2'd2) begin
            state     <= ST_WAIT;
            row_rd_en <= 1'b0;
            wait_cnt  <= '0;
          end else begin
            ld_cnt      <= ld_cnt + 2'd1;
            row_rd_addr <= top_row + ADDR_W'(ld_cnt + 2'd1);
          end
        end

        ST_WAIT: begin
          if (wait_cnt == WC_LAST) begin
            res_valid <= 1'b1;
            res_data  <= {relu_lane(pe_data_out2), relu_lane(pe_data_out1),
                          relu_lane(pe_data_out0)};
            res_row   <= top_row;
            if (top_row == LAST_TOP) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              top_row <= top_row + 1'b1;
              state   <= ST_GAP;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // Only start the next window once the result register is guaranteed
        // empty by its capture, so no PE result can be overwritten.
        ST_GAP: begin
          if (!res_valid || drain) begin
            state       <= ST_LOAD;
            ld_cnt      <= '0;
            row_rd_en   <= 1'b1;
            row_rd_addr <= top_row;
          end
        end

        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pe_seq.sv
// Bench for conv_pe_seq: ROWS=5 instance with a row-memory/PE model and a
// scoreboard of expected reads and results, plus a ROWS=3 instance.
module tb_conv_pe_seq;

  localparam int WIDTH  = 9;
  localparam int ADDR_W = 5;
  localparam int PE_LAT = 2;
  localparam int ROWS   = 5;

`ifdef CONV_PE_SEQ_RELU_EN
  localparam logic [3*WIDTH-1:0] WIN0_EXP = {9'h000, 9'h00A, 9'h005};
  localparam logic [3*WIDTH-1:0] R3_EXP   = {9'h07F, 9'h000, 9'h03C};
`else
  localparam logic [3*WIDTH-1:0] WIN0_EXP = {9'h1FF, 9'h00A, 9'h005};
  localparam logic [3*WIDTH-1:0] R3_EXP   = {9'h07F, 9'h1A0, 9'h03C};
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, busy, done, row_rd_en, pe_init;
  logic [ADDR_W-1:0] row_rd_addr;
  logic [WIDTH-1:0]  pe0, pe1, pe2;

  logic              start3, busy3, done3, rd_en3, init3;
  logic [ADDR_W-1:0] addr3;
  logic [WIDTH-1:0]  lane3_0, lane3_1, lane3_2;

  conv_pe_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) res_if ();
  conv_pe_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) res3_if ();

  conv_pe_seq #(.WIDTH(WIDTH), .ROWS(ROWS), .ADDR_W(ADDR_W), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .row_rd_en(row_rd_en), .row_rd_addr(row_rd_addr), .pe_init(pe_init),
    .pe_data_out0(pe0), .pe_data_out1(pe1), .pe_data_out2(pe2),
    .res(res_if.master)
  );

  conv_pe_seq #(.WIDTH(WIDTH), .ROWS(3), .ADDR_W(ADDR_W), .PE_LAT(PE_LAT)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .row_rd_en(rd_en3), .row_rd_addr(addr3), .pe_init(init3),
    .pe_data_out0(lane3_0), .pe_data_out1(lane3_1), .pe_data_out2(lane3_2),
    .res(res3_if.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_lane();
    logic [31:0] r;
    r = $urandom;
    return r[WIDTH-1:0];
  endfunction

  function automatic logic rnd_bit();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // Reference lane conditioning: negative (MSB set) lanes become zero when enabled.
  function automatic logic [WIDTH-1:0] ref_relu(input logic [WIDTH-1:0] v);
`ifdef CONV_PE_SEQ_RELU_EN
    return v[WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Row memory contents and the scoreboards of one job.
  logic [WIDTH-1:0]   mem [32];
  logic [ADDR_W-1:0]  exp_addr [$];
  logic [3*WIDTH-1:0] exp_data [$];
  logic [ADDR_W-1:0]  exp_row  [$];

  task automatic queue_job();
    for (int w = 0; w <= ROWS - 3; w++) begin
      for (int k = 0; k < 3; k++) exp_addr.push_back(ADDR_W'(w + k));
      exp_data.push_back({ref_relu(mem[w+2]), ref_relu(mem[w+1]), ref_relu(mem[w])});
      exp_row.push_back(ADDR_W'(w));
    end
  endtask

  task automatic flush_sb();
    exp_addr.delete();
    exp_data.delete();
    exp_row.delete();
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) mem[i] = rnd_lane();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory + PE model and result scoreboard, sampled mid-cycle.
  logic [7:0]        hist;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] ld [$];
  int                hs_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hist = '0;
      ld.delete();
      pe0 = rnd_lane(); pe1 = rnd_lane(); pe2 = rnd_lane();
    end else begin
      if (pe_init) ld.push_back(pend_addr);
      if (row_rd_en) begin
        if (exp_addr.size() == 0) chk("rd_unexpected", row_rd_en, 1'b0);
        else chk("rd_addr", row_rd_addr, exp_addr.pop_front());
        pend_addr = row_rd_addr;
      end
      hist = {hist[6:0], pe_init};
      // PE lanes are only meaningful exactly PE_LAT cycles after the last load.
      if (hist[PE_LAT] && !hist[PE_LAT-1] && ld.size() >= 3) begin
        pe0 = mem[ld[$-2]];
        pe1 = mem[ld[$-1]];
        pe2 = mem[ld[$]];
      end else begin
        pe0 = rnd_lane(); pe1 = rnd_lane(); pe2 = rnd_lane();
      end
      if (res_if.out_valid && res_if.out_ready) begin
        hs_cnt++;
        if (exp_data.size() == 0) chk("res_unexpected", res_if.out_valid, 1'b0);
        else begin
          chk("res_data", res_if.out_data, exp_data.pop_front());
          chk("res_row", res_if.out_row, exp_row.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, row_rd_en, 1'b0);
    chk({tag, "_rd_addr"}, row_rd_addr, '0);
    chk({tag, "_pe_init"}, pe_init, 1'b0);
    chk({tag, "_vld"}, res_if.out_valid, 1'b0);
    chk({tag, "_data"}, res_if.out_data, '0);
    chk({tag, "_row"}, res_if.out_row, '0);
  endtask

  // Runs the current job to completion with random backpressure, optionally
  // pulsing start while busy; returns the number of done pulses seen.
  task automatic drain_job(input bit poke_start, output int dcnt);
    int n;
    n = 0;
    dcnt = 0;
    while ((busy || res_if.out_valid || exp_data.size() != 0) && n < 500) begin
      start = (poke_start && busy) ? rnd_bit() : 1'b0;
      res_if.out_ready = rnd_bit();
      tick();
      if (done) dcnt++;
      n++;
    end
    start = 1'b0;
    res_if.out_ready = 1'b1;
    chk("job_timeout", n < 500, 1'b1);
    chk("job_sb_data", exp_data.size(), 0);
    chk("job_sb_addr", exp_addr.size(), 0);
    chk("job_idle", busy, 1'b0);
  endtask

  initial begin
    int vcnt, dcnt, n, hs0, v3;
    logic [3*WIDTH-1:0] held;

    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    res_if.out_ready = 1'b1; res3_if.out_ready = 1'b1;
    lane3_0 = 9'h03C; lane3_1 = 9'h1A0; lane3_2 = 9'h07F;
    randomize_mem();
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Directed job: nominal timing and the window-0 lane values.
    mem[0] = 9'h005; mem[1] = 9'h00A; mem[2] = 9'h1FF;
    queue_job();
    start = 1'b1;
    vcnt = 0; dcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) begin
        chk("a_rd_en_t0", row_rd_en, 1'b1);
        chk("a_busy_t0", busy, 1'b1);
      end
      if (c == 2) chk("a_pe_init_t1", pe_init, 1'b1);
      if (res_if.out_valid) begin
        vcnt++;
        chk("a_vld_cycle", c, 7 * vcnt);
      end
      if (c == 7) chk("a_win0_data", res_if.out_data, WIN0_EXP);
      if (done) begin
        dcnt++;
        chk("a_done_cycle", c, 21);
      end
    end
    chk("a_results", vcnt, 3);
    chk("a_dones", dcnt, 1);
    chk("a_busy_end", busy, 1'b0);
    chk("a_sb_empty", exp_data.size(), 0);

    // Backpressure: hold out_ready low for 20 cycles after the first result.
    randomize_mem();
    queue_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!res_if.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_first_vld", res_if.out_valid, 1'b1);
    res_if.out_ready = 1'b0;
    held = res_if.out_data;
    repeat (20) begin
      tick();
      chk("bp_rd_en", row_rd_en, 1'b0);
      chk("bp_vld", res_if.out_valid, 1'b1);
      chk("bp_data", res_if.out_data, held);
      chk("bp_busy", busy, 1'b1);
    end
    res_if.out_ready = 1'b1;
    tick();
    chk("bp_load", row_rd_en, 1'b1);
    chk("bp_drained", res_if.out_valid, 1'b0);
    drain_job(1'b0, dcnt);
    chk("bp_dones", dcnt, 1);

    // Repeated start while busy, random backpressure, several jobs.
    for (int j = 0; j < 3; j++) begin
      randomize_mem();
      queue_job();
      hs0 = hs_cnt;
      start = 1'b1;
      tick();
      drain_job(1'b1, dcnt);
      chk("st_dones", dcnt, 1);
      chk("st_results", hs_cnt - hs0, ROWS - 2);
    end

    // Reset during WAIT of window 1, then restart from row 0.
    randomize_mem();
    queue_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("rs_in_wait_busy", busy, 1'b1);
    chk("rs_in_wait_rd", row_rd_en, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset_vals("rs_abort");
    flush_sb();
    rst_n = 1'b1;
    tick();
    randomize_mem();
    queue_job();
    hs0 = hs_cnt;
    start = 1'b1;
    tick();
    chk("rs_restart_addr", row_rd_addr, '0);
    drain_job(1'b0, dcnt);
    chk("rs_results", hs_cnt - hs0, ROWS - 2);

    // ROWS=3 instance: single window.
    v3 = 0;
    start3 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start3 = 1'b0;
      if (res3_if.out_valid) begin
        v3++;
        chk("r3_vld_cycle", c, 7);
        chk("r3_row", res3_if.out_row, '0);
        chk("r3_data", res3_if.out_data, R3_EXP);
      end
      if (done3) chk("r3_done_cycle", c, 7);
    end
    chk("r3_results", v3, 1);
    chk("r3_busy_end", busy3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_pe_seq.md
# conv_pe_seq

Sequencer for the 3x3 convolution processing element. Walks a row-buffer memory top to bottom and, for each output row, issues three consecutive row reads with `pe_init` aligned to the returned data. It waits the PE latency, captures the three PE output lanes into a one-deep result register, and hands them downstream over a valid/ready handshake. It sits between the input line memory and the PE/result path, and is the only block that drives `pe_init`.

## Interface
- `WIDTH`, 9: lane width of PE data and outputs.
- `ROWS`, 32: image height in rows; must be ≥3.
- `ADDR_W`, 5: row address width; must satisfy 2^ADDR_W ≥ ROWS.
- `PE_LAT`, 2: cycles from the last `pe_init`-high cycle to the cycle whose PE outputs are sampled; must be ≥1.

- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: job request; sampled only in IDLE.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job end.
- `row_rd_en` out 1: row memory read strobe; the memory has 1-cycle read latency.
- `row_rd_addr` out ADDR_W: row to read.
- `pe_init` out 1: PE row-load qualifier.
- `pe_data_out0`/`pe_data_out1`/`pe_data_out2` in WIDTH each: PE result lanes.
- `out_valid` out 1: result register full.
- `out_ready` in 1: downstream accepts.
- `out_data` out 3*WIDTH: {lane2, lane1, lane0}.
- `out_row` out ADDR_W: top row index of the window that produced `out_data`.

## Operation
- States: IDLE, LOAD, WAIT, GAP, FIN.
- IDLE:
  - `start`=1 → LOAD with window top row r=0 and load counter k=0.
  - `start` in any other state is ignored.
- LOAD:
  - Drives `row_rd_en`=1 and `row_rd_addr`=r+k for k=0,1,2, one per cycle.
  - After k=2 → WAIT.
- `pe_init` is `row_rd_en` delayed one cycle, so it is high for exactly 3 cycles per window.
- WAIT:
  - Counts PE_LAT+1 cycles; the first of these cycles is the last `pe_init`-high cycle.
  - In the final WAIT cycle (capture cycle), the PE lanes are registered into `out_data`, `out_row`←r, and `out_valid`←1.
- After the capture cycle:
  - If r = ROWS-3 → FIN.
  - Else r←r+1 and go to GAP.
- GAP: → LOAD in any cycle where `out_valid`=0 or (`out_valid` & `out_ready`); otherwise hold in GAP.
  - This rule guarantees the result register is empty at the next capture, so no PE result is ever dropped.
- FIN: one cycle with `done`=1 → IDLE.
- `busy`=1 in LOAD, WAIT, GAP; 0 in IDLE and FIN.
- Result register:
  - Cleared (`out_valid`←0) on `out_valid` & `out_ready`.
  - Capture and drain in the same cycle cannot occur.
  - The register may still be full after `done`; it keeps handshaking in IDLE.
- Stride is 1, giving ROWS-2 windows per job; `out_row` takes values 0..ROWS-3 in order.
- No arithmetic is performed on lanes except the optional ReLU (see Configuration).
- Row addresses never exceed ROWS-1.

## Timing
- t0 = first LOAD cycle, which is the cycle after `start` is sampled in IDLE.
- `row_rd_en`: high t0..t0+2.
- `pe_init`: high t0+1..t0+3.
- Capture: at the edge ending cycle t0+3+PE_LAT.
- `out_valid` rises at t0+4+PE_LAT.
- Window period with `out_ready`=1: 5+PE_LAT cycles (LOAD 3 + WAIT PE_LAT+1 + GAP 1); 7 at defaults.
- `done`: the cycle after the final capture, coincident with the last `out_valid` rise.
- Reset values: `busy`=0, `done`=0, `row_rd_en`=0, `row_rd_addr`=0, `pe_init`=0, `out_valid`=0, `out_data`=0, `out_row`=0; state IDLE with counters 0.
- `rst_n` low mid-job aborts immediately: all of the above reset values apply at the next edge, and any pending result is discarded.

## Configuration
- `CONV_PE_SEQ_RELU_EN` defined: each lane is treated as two's-complement at capture; a lane with MSB=1 is stored as 0, otherwise it is stored unchanged.
- `CONV_PE_SEQ_RELU_EN` undefined: lanes are stored verbatim.
- Timing is identical either way.

## Test plan
- ROWS=5, PE_LAT=2, `out_ready`=1, `start` pulse at cycle 0:
  - read addrs 0,1,2 | 1,2,3 | 2,3,4.
  - 3 results with `out_row`=0,1,2.
  - first `out_valid` at cycle 7, then every 7 cycles.
  - `done` with the third result; `busy` low afterwards.
- PE model returns lanes 0x005/0x00A/0x1FF for window 0 → `out_data`={0x1FF,0x00A,0x005}.
  - With `CONV_PE_SEQ_RELU_EN`: `out_data`={0x000,0x00A,0x005}.
- `out_ready`=0 for 20 cycles after the first result:
  - FSM holds in GAP.
  - `row_rd_en` stays low.
  - `out_data` stays stable.
  - `out_ready`=1 → next LOAD begins the same cycle the handshake completes.
  - No result is lost or duplicated.
- `start` pulsed repeatedly while `busy`: ignored; exactly ROWS-2 results are produced per job.
- `rst_n` low in WAIT of window 1: the next cycle shows all outputs at reset values and state IDLE; a following `start` restarts from row 0.
- ROWS=3: a single window, `out_row`=0; `done` at cycle 7 with `out_ready`=1.
